// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter, one 2-entry FIFO per unit.
// Macro CDB_AGE_PRIO_EN selects oldest-ROB-first; else round-robin.
module cdb_arbiter #(
  parameter int N_SRC  = 3,
  parameter int TAG_W  = 3,
  parameter int DATA_W = 16
) (
  input  logic                    clk1,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic [TAG_W-1:0]        head_p,
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*TAG_W-1:0]  req_tag,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  output logic [N_SRC-1:0]        req_ready,
  output logic                    cdb_valid,
  output logic [TAG_W-1:0]        cdb_tag,
  output logic [DATA_W-1:0]       cdb_data,
  output logic [N_SRC-1:0]        cdb_src,
  output logic [7:0]              conflict_cnt
);

  localparam int EW = TAG_W + DATA_W;
  localparam int SW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(N_SRC + 1);

  logic [EW-1:0]     mem_q [N_SRC][2];
  logic [N_SRC-1:0]  wp_q, wp_d;
  logic [N_SRC-1:0]  rp_q, rp_d;
  logic [1:0]        cnt_q [N_SRC];
  logic [1:0]        cnt_d [N_SRC];
  logic [N_SRC-1:0]  ne, push, pop;
  logic [EW-1:0]     head [N_SRC];
  logic              any;
  logic [SW-1:0]     win;
  logic [SW-1:0]     rr_q, rr_d;
  logic              v_q, v_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_SRC-1:0]  src_q, src_d;
  logic [7:0]        cc_q, cc_d;
  logic [CW-1:0]     n_ne;

  // Queue status: ready depends only on registered count and flush
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      ne[i]        = cnt_q[i] != 2'd0;
      req_ready[i] = rst_n && !flush && (cnt_q[i] < 2'd2);
      push[i]      = req_valid[i] && req_ready[i];
      head[i]      = mem_q[i][rp_q[i]];
    end
  end

`ifdef CDB_AGE_PRIO_EN
  logic [TAG_W-1:0] age [N_SRC];
  logic [TAG_W-1:0] best;
  logic             unused_rr;

  assign unused_rr = ^rr_q;

  // Oldest head relative to ROB head wins; ties go to lowest index
  always_comb begin
    any  = 1'b0;
    win  = '0;
    best = '0;
    for (int i = 0; i < N_SRC; i++) begin
      age[i] = head[i][EW-1 -: TAG_W] - head_p;
      if (ne[i] && (!any || age[i] < best)) begin
        any  = 1'b1;
        win  = SW'(i);
        best = age[i];
      end
    end
  end
`else
  logic [SW:0] idx;
  logic        unused_hp;

  assign unused_hp = ^head_p;

  // First non-empty queue at or after rr, wrapping
  always_comb begin
    any = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = {1'b0, rr_q} + (SW+1)'(k);
      if (idx >= (SW+1)'(N_SRC))
        idx = idx - (SW+1)'(N_SRC);
      if (!any && ne[idx[SW-1:0]]) begin
        any = 1'b1;
        win = idx[SW-1:0];
      end
    end
  end
`endif

  // Pop the winner unless the pipeline is being squashed
  always_comb begin
    pop = '0;
    if (any && !flush)
      pop[win] = 1'b1;
  end

  // Queue pointer and occupancy update
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      wp_d[i]  = wp_q[i];
      rp_d[i]  = rp_q[i];
      cnt_d[i] = cnt_q[i];
      if (flush) begin
        wp_d[i]  = 1'b0;
        rp_d[i]  = 1'b0;
        cnt_d[i] = 2'd0;
      end else begin
        if (push[i]) wp_d[i] = ~wp_q[i];
        if (pop[i])  rp_d[i] = ~rp_q[i];
        cnt_d[i] = cnt_q[i] + {1'b0, push[i]}
                 - {1'b0, pop[i]};
      end
    end
  end

  // Round-robin pointer moves past each winner; held at 0 in age mode
  always_comb begin
    rr_d = rr_q;
`ifndef CDB_AGE_PRIO_EN
    if (flush)
      rr_d = '0;
    else if (any)
      rr_d = (win == SW'(N_SRC-1)) ? '0 : win + 1'b1;
`endif
  end

  // Broadcast next state; tag/data hold when idle
  always_comb begin
    v_d    = 1'b0;
    src_d  = '0;
    tag_d  = tag_q;
    data_d = data_q;
    if (!flush && any) begin
      v_d            = 1'b1;
      src_d[win]     = 1'b1;
      {tag_d, data_d} = head[win];
    end
  end

  // Count cycles where two or more queues hold results
  always_comb begin
    n_ne = '0;
    for (int i = 0; i < N_SRC; i++)
      n_ne = n_ne + CW'(ne[i]);
    cc_d = cc_q;
    if (n_ne >= CW'(2) && cc_q != 8'hFF)
      cc_d = cc_q + 8'd1;
  end

  // Queue storage
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SRC; i++) begin
        mem_q[i][0] <= '0;
        mem_q[i][1] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SRC; i++)
        if (push[i])
          mem_q[i][wp_q[i]] <= {req_tag[i*TAG_W +: TAG_W],
                                req_data[i*DATA_W +: DATA_W]};
    end
  end

  // Queue control and arbitration state
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      rr_q <= '0;
      for (int i = 0; i < N_SRC; i++)
        cnt_q[i] <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      rr_q <= rr_d;
      for (int i = 0; i < N_SRC; i++)
        cnt_q[i] <= cnt_d[i];
    end
  end

  // Registered CDB and conflict counter
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= 1'b0;
      tag_q  <= '0;
      data_q <= '0;
      src_q  <= '0;
      cc_q   <= '0;
    end else begin
      v_q    <= v_d;
      tag_q  <= tag_d;
      data_q <= data_d;
      src_q  <= src_d;
      cc_q   <= cc_d;
    end
  end

  assign cdb_valid    = v_q;
  assign cdb_tag      = tag_q;
  assign cdb_data     = data_q;
  assign cdb_src      = src_q;
  assign conflict_cnt = cc_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed plus random checks of cdb_arbiter
// against a queue-level model of the bus.
module tb_cdb_arbiter;

  logic        clk1;
  logic        rst_n;
  logic        flush;
  logic [2:0]  head_p;
  logic [2:0]  req_valid;
  logic [8:0]  req_tag;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic [2:0]  cdb_src;
  logic [7:0]  conflict_cnt;

  cdb_arbiter #(.N_SRC(3), .TAG_W(3), .DATA_W(16)) dut (
    .clk1(clk1), .rst_n(rst_n), .flush(flush),
    .head_p(head_p), .req_valid(req_valid),
    .req_tag(req_tag), .req_data(req_data),
    .req_ready(req_ready), .cdb_valid(cdb_valid),
    .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .cdb_src(cdb_src), .conflict_cnt(conflict_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: each unit owns a list of up to two {tag,data} entries
  logic [2:0]  mq_tag [3][2];
  logic [15:0] mq_dat [3][2];
  int          msz [3];
  logic        m_valid = 0;
  logic [2:0]  m_tag = 0;
  logic [15:0] m_data = 0;
  logic [2:0]  m_src = 0;
  int          m_cc = 0;
  int          m_rr = 0;
  int          m_w, m_ne, m_best, m_age, m_j;
  bit          m_acc [3];

  initial for (int i = 0; i < 3; i++) msz[i] = 0;

  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) msz[i] = 0;
      m_valid = 0; m_tag = 0; m_data = 0;
      m_src = 0; m_cc = 0; m_rr = 0;
    end else begin
      m_ne = 0;
      for (int i = 0; i < 3; i++) if (msz[i] > 0) m_ne++;
      if (m_ne >= 2 && m_cc < 255) m_cc++;
      if (flush) begin
        for (int i = 0; i < 3; i++) msz[i] = 0;
        m_valid = 0; m_src = 0; m_rr = 0;
      end else begin
        for (int i = 0; i < 3; i++)
          m_acc[i] = req_valid[i] && msz[i] < 2;
        m_w = -1;
`ifdef CDB_AGE_PRIO_EN
        m_best = 99;
        for (int i = 0; i < 3; i++)
          if (msz[i] > 0) begin
            m_age = (int'(mq_tag[i][0]) - int'(head_p) + 8) % 8;
            if (m_age < m_best) begin
              m_best = m_age; m_w = i;
            end
          end
`else
        for (int k = 0; k < 3; k++) begin
          m_j = (m_rr + k) % 3;
          if (m_w < 0 && msz[m_j] > 0) m_w = m_j;
        end
`endif
        if (m_w >= 0) begin
          m_valid = 1;
          m_tag   = mq_tag[m_w][0];
          m_data  = mq_dat[m_w][0];
          m_src   = 3'(1 << m_w);
          mq_tag[m_w][0] = mq_tag[m_w][1];
          mq_dat[m_w][0] = mq_dat[m_w][1];
          msz[m_w]--;
`ifndef CDB_AGE_PRIO_EN
          m_rr = (m_w + 1) % 3;
`endif
        end else begin
          m_valid = 0; m_src = 0;
        end
        for (int i = 0; i < 3; i++)
          if (m_acc[i]) begin
            mq_tag[i][msz[i]] = req_tag[i*3 +: 3];
            mq_dat[i][msz[i]] = req_data[i*16 +: 16];
            msz[i]++;
          end
      end
    end
  end

  logic [2:0] mul_seen [$];
  logic [2:0] er;

  // Compare DUT against model every cycle, away from the edge
  always @(negedge clk1) begin
    #1;
    for (int i = 0; i < 3; i++)
      er[i] = rst_n && !flush && msz[i] < 2;
    chk("cdb_valid", 32'(cdb_valid), 32'(m_valid));
    chk("cdb_tag", 32'(cdb_tag), 32'(m_tag));
    chk("cdb_data", 32'(cdb_data), 32'(m_data));
    chk("cdb_src", 32'(cdb_src), 32'(m_src));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(m_cc));
    chk("req_ready", 32'(req_ready), 32'(er));
    if (cdb_valid && cdb_src == 3'b010)
      mul_seen.push_back(cdb_tag);
  end

  task automatic drive(input logic r, input logic f,
                       input logic [2:0] v,
                       input logic [8:0] t,
                       input logic [47:0] d,
                       input logic [2:0] hp);
    @(negedge clk1);
    rst_n = r; flush = f; req_valid = v;
    req_tag = t; req_data = d; head_p = hp;
  endtask

  task automatic idle(input logic [2:0] hp);
    drive(1'b1, 1'b0, 3'b000, 9'd0, 48'd0, hp);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 3'b000, 9'd0, 48'd0, 3'd0);
    idle(3'd0);
  endtask

  logic [2:0] ord_src [3];
  logic [2:0] ord_tag [3];

  task automatic round3(input int cc_exp);
    drive(1'b1, 1'b0, 3'b111, {3'd0, 3'd7, 3'd1},
          {16'hB000, 16'hA000, 16'hC000}, 3'd6);
    idle(3'd6); #2;
    chk("ct_idle", 32'(cdb_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(3'd6); #2;
      chk("ct_valid", 32'(cdb_valid), 32'd1);
      chk("ct_src", 32'(cdb_src), 32'(ord_src[k]));
      chk("ct_tag", 32'(cdb_tag), 32'(ord_tag[k]));
    end
    idle(3'd6); #2;
    chk("ct_drained", 32'(cdb_valid), 32'd0);
    chk("ct_conflict", 32'(conflict_cnt), 32'(cc_exp));
  endtask

  logic        got;
  logic [8:0]  rt;
  logic [47:0] rd;
  logic        rr_n, rf;

  initial begin
`ifdef CDB_AGE_PRIO_EN
    ord_src[0] = 3'b010; ord_src[1] = 3'b100; ord_src[2] = 3'b001;
    ord_tag[0] = 3'd7;   ord_tag[1] = 3'd0;   ord_tag[2] = 3'd1;
`else
    ord_src[0] = 3'b001; ord_src[1] = 3'b010; ord_src[2] = 3'b100;
    ord_tag[0] = 3'd1;   ord_tag[1] = 3'd7;   ord_tag[2] = 3'd0;
`endif
    rst_n = 1'b0; flush = 1'b0; head_p = 3'd0;
    req_valid = 3'b000; req_tag = '0; req_data = '0;

    // Reset with requests asserted
    drive(1'b0, 1'b0, 3'b111, 9'h1FF, 48'hFFFF_FFFF_FFFF, 3'd0);
    drive(1'b0, 1'b0, 3'b111, 9'h1FF, 48'hFFFF_FFFF_FFFF, 3'd0);
    #2;
    chk("rst_valid", 32'(cdb_valid), 32'd0);
    chk("rst_tag", 32'(cdb_tag), 32'd0);
    chk("rst_data", 32'(cdb_data), 32'd0);
    chk("rst_src", 32'(cdb_src), 32'd0);
    chk("rst_cc", 32'(conflict_cnt), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    idle(3'd0); #2;
    chk("post_rst_ready", 32'(req_ready), 32'h7);

    // Single uncontended result: one cycle of latency
    drive(1'b1, 1'b0, 3'b001, {6'd0, 3'd2}, 48'h0005, 3'd0);
    idle(3'd0); #2;
    chk("single_early", 32'(cdb_valid), 32'd0);
    idle(3'd0); #2;
    chk("single_valid", 32'(cdb_valid), 32'd1);
    chk("single_tag", 32'(cdb_tag), 32'd2);
    chk("single_data", 32'(cdb_data), 32'h5);
    chk("single_src", 32'(cdb_src), 32'b001);
    idle(3'd0); #2;
    chk("single_once", 32'(cdb_valid), 32'd0);

    // Three-way contention, twice
    do_reset();
    round3(2);
    round3(4);

    // Backpressure on the multiplier queue
    do_reset();
    mul_seen.delete();
    drive(1'b1, 1'b0, 3'b111, {3'd6, 3'd3, 3'd0},
          {16'h6666, 16'h3333, 16'h0000}, 3'd0);
    drive(1'b1, 1'b0, 3'b011, {3'd0, 3'd4, 3'd1},
          {16'h0, 16'h4444, 16'h1111}, 3'd0);
    #2;
    chk("bp_ready1", 32'(req_ready), 32'h7);
    drive(1'b1, 1'b0, 3'b010, {3'd0, 3'd5, 3'd0},
          {16'h0, 16'h5555, 16'h0}, 3'd0);
    #1;
    chk("bp_full", 32'(req_ready), 32'b101);
    got = req_ready[1];
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, got ? 3'b000 : 3'b010,
            {3'd0, 3'd5, 3'd0}, {16'h0, 16'h5555, 16'h0}, 3'd0);
      #1;
      if (!got && req_ready[1]) got = 1'b1;
    end
    chk("bp_accepted", 32'(got), 32'd1);
    for (int k = 0; k < 4; k++) idle(3'd0);
    #2;
    chk("bp_count", 32'(mul_seen.size()), 32'd3);
    for (int k = 0; k < mul_seen.size() && k < 3; k++)
      chk("bp_order", 32'(mul_seen[k]), 32'(3 + k));

    // Flush with results queued
    do_reset();
    drive(1'b1, 1'b0, 3'b011, {3'd0, 3'd2, 3'd1},
          {16'h0, 16'h2222, 16'h1111}, 3'd0);
    drive(1'b1, 1'b1, 3'b111, 9'h1FF, 48'h1, 3'd0);
    #2;
    chk("fl_ready", 32'(req_ready), 32'd0);
    idle(3'd0); #2;
    chk("fl_valid", 32'(cdb_valid), 32'd0);
    chk("fl_src", 32'(cdb_src), 32'd0);
    chk("fl_ready_after", 32'(req_ready), 32'h7);
    idle(3'd0); #2;
    chk("fl_no_stale", 32'(cdb_valid), 32'd0);
    idle(3'd0); #2;
    chk("fl_no_stale2", 32'(cdb_valid), 32'd0);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 4000; n++) begin
      rr_n = ($urandom_range(0, 299) != 0);
      rf   = ($urandom_range(0, 24) == 0);
      rt   = 9'($urandom);
      rd[31:0]  = $urandom;
      rd[47:32] = 16'($urandom);
      drive(rr_n, rf, 3'($urandom), rt, rd,
            3'($urandom));
    end
    for (int k = 0; k < 5; k++) idle(3'd0);
    #2;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
